// File: rtl/tdm_burst_scheduler.sv
// Fixed-slot TDM scheduler: NUM_CH requesters share one link in frames of (GUARD idle + SLOT_LEN beat) slots.
// Accepted beats appear one cycle later; in_ready is the only flow control and the link never stalls.
module tdm_burst_scheduler #(
    parameter  int NUM_CH   = 4,
    parameter  int SLOT_LEN = 16,
    parameter  int GUARD    = 2,
    parameter  int DATA_W   = 8,
    localparam int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CW-1:0]            out_ch,
    output logic                     slot_start,
    output logic                     frame_start,
    output logic                     slot_empty
);

    localparam int BW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

    localparam logic [BW-1:0]     BEAT_LAST  = BW'(SLOT_LEN - 1);
    localparam logic [GW-1:0]     GUARD_LAST = GW'((GUARD > 0) ? GUARD - 1 : 0);
    localparam logic [CW-1:0]     CH_LAST    = CW'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] ONE_HOT0   = NUM_CH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GUARD,
        S_SLOT
    } state_t;

    // With no guard interval every run/slot boundary goes straight into the next slot.
    localparam state_t RUN_ENTRY = (GUARD == 0) ? S_SLOT : S_GUARD;

    state_t        state, state_nxt;
    logic [CW-1:0] cur_ch, cur_ch_nxt;
    logic [BW-1:0] beat_cnt, beat_cnt_nxt;
    logic [GW-1:0] guard_cnt, guard_cnt_nxt;
    logic          xfer_seen;

    logic in_slot;
    logic slot_last;
    logic xfer;
    logic seen_now;

    assign in_slot     = (state == S_SLOT);
    assign slot_last   = in_slot && (beat_cnt == BEAT_LAST);
    assign xfer        = in_slot && in_valid[cur_ch];
    assign in_ready    = (in_slot && !rst) ? (ONE_HOT0 << cur_ch) : '0;
    assign slot_start  = in_slot && (beat_cnt == '0);
    assign frame_start = slot_start && (cur_ch == '0);
    // Stale history is ignored on the first slot cycle so a fresh slot starts clean.
    assign seen_now    = (slot_start ? 1'b0 : xfer_seen) | xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cur_ch    <= '0;
            beat_cnt  <= '0;
            guard_cnt <= '0;
        end else begin
            state     <= state_nxt;
            cur_ch    <= cur_ch_nxt;
            beat_cnt  <= beat_cnt_nxt;
            guard_cnt <= guard_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cur_ch_nxt    = cur_ch;
        beat_cnt_nxt  = beat_cnt;
        guard_cnt_nxt = guard_cnt;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_nxt     = RUN_ENTRY;
                    cur_ch_nxt    = '0;
                    beat_cnt_nxt  = '0;
                    guard_cnt_nxt = '0;
                end
            end
            S_GUARD: begin
                if (guard_cnt == GUARD_LAST) begin
                    state_nxt     = S_SLOT;
                    guard_cnt_nxt = '0;
                    beat_cnt_nxt  = '0;
                end else begin
                    guard_cnt_nxt = guard_cnt + 1'b1;
                end
            end
            S_SLOT: begin
                if (slot_last) begin
                    beat_cnt_nxt = '0;
                    cur_ch_nxt   = (cur_ch == CH_LAST) ? '0 : cur_ch + 1'b1;
                    state_nxt    = enable ? RUN_ENTRY : S_IDLE;
                end else begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            xfer_seen  <= 1'b0;
            slot_empty <= 1'b0;
        end else begin
            out_valid  <= xfer;
            if (xfer) begin
                out_data <= in_data[cur_ch*DATA_W +: DATA_W];
                out_ch   <= cur_ch;
            end
            xfer_seen  <= seen_now;
            slot_empty <= slot_last && !seen_now;
        end
    end

endmodule

// File: tb/tb_tdm_burst_scheduler.sv
// Randomized scoreboard bench for two scheduler configurations against a frame-arithmetic model.
module tb_tdm_burst_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v [2];
    logic        en_v  [2];
    logic [3:0]  iv    [2];
    logic [31:0] idat  [2];

    logic [3:0] a_ready;
    logic       a_ov, a_ss, a_fs, a_se;
    logic [7:0] a_od;
    logic [1:0] a_oc;
    logic [1:0] b_ready;
    logic       b_ov, b_ss, b_fs, b_se;
    logic [7:0] b_od;
    logic [0:0] b_oc;

    tdm_burst_scheduler #(.NUM_CH(4), .SLOT_LEN(16), .GUARD(2), .DATA_W(8)) dut_a (
        .clk(clk), .rst(rst_v[0]), .enable(en_v[0]),
        .in_valid(iv[0]), .in_data(idat[0]), .in_ready(a_ready),
        .out_valid(a_ov), .out_data(a_od), .out_ch(a_oc),
        .slot_start(a_ss), .frame_start(a_fs), .slot_empty(a_se)
    );

    tdm_burst_scheduler #(.NUM_CH(2), .SLOT_LEN(1), .GUARD(0), .DATA_W(8)) dut_b (
        .clk(clk), .rst(rst_v[1]), .enable(en_v[1]),
        .in_valid(iv[1][1:0]), .in_data(idat[1][15:0]), .in_ready(b_ready),
        .out_valid(b_ov), .out_data(b_od), .out_ch(b_oc),
        .slot_start(b_ss), .frame_start(b_fs), .slot_empty(b_se)
    );

    int P_N [2] = '{4, 2};
    int P_S [2] = '{16, 1};
    int P_G [2] = '{2, 0};

    typedef struct {
        int         due;
        logic [7:0] d;
        int         ch;
    } exp_t;

    exp_t sbq [2][$];

    bit running   [2];
    int n         [2];
    bit seen      [2];
    bit exp_empty [2];
    bit primed;
    int cyc;
    int checks;
    int errors;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int id, input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, id, cyc, act, want);
        end
    endtask

    task automatic sample(input int id, output logic [31:0] rdy, output logic [31:0] ss,
                          output logic [31:0] fs, output logic [31:0] se, output logic [31:0] ov,
                          output logic [31:0] od, output logic [31:0] oc);
        if (id == 0) begin
            rdy = 32'(a_ready); ss = 32'(a_ss); fs = 32'(a_fs); se = 32'(a_se);
            ov = 32'(a_ov); od = 32'(a_od); oc = 32'(a_oc);
        end else begin
            rdy = 32'(b_ready); ss = 32'(b_ss); fs = 32'(b_fs); se = 32'(b_se);
            ov = 32'(b_ov); od = 32'(b_od); oc = 32'(b_oc);
        end
    endtask

    // Stimulus phases: reset, full load, ch2 silent, ch1 alternating, random enable, random reset, drain.
    task automatic drive(input int id, input int k);
        rst_v[id] = (k < 3);
        en_v[id]  = 1'b1;
        iv[id]    = 4'($urandom);
        idat[id]  = $urandom;
        if (k < 170) begin
            iv[id] = 4'hF;
        end else if (k < 320) begin
            iv[id][2] = 1'b0;
        end else if (k < 470) begin
            iv[id][1] = (k % 2 == 0);
        end else if (k < 800) begin
            en_v[id] = ($urandom_range(0, 7) != 0);
        end else if (k < 1200) begin
            en_v[id]  = ($urandom_range(0, 15) != 0);
            rst_v[id] = ($urandom_range(0, 39) == 0);
        end else begin
            en_v[id] = 1'b0;
            iv[id]   = 4'h0;
        end
    endtask

    // Model: position in the running schedule is cycles since run start modulo the frame period.
    task automatic step(input int id, input int k);
        int L, p, w, ch, beat;
        bit in_slot, ss, fs, xfer, last;
        logic [31:0] d_rdy, d_ss, d_fs, d_se, d_ov, d_od, d_oc;
        sample(id, d_rdy, d_ss, d_fs, d_se, d_ov, d_od, d_oc);
        L = P_G[id] + P_S[id];
        in_slot = 1'b0; ch = 0; beat = 0;
        if (running[id]) begin
            p       = n[id] % (P_N[id] * L);
            ch      = p / L;
            w       = p % L;
            in_slot = (w >= P_G[id]);
            beat    = w - P_G[id];
        end
        ss   = in_slot && (beat == 0);
        fs   = ss && (ch == 0);
        last = in_slot && (beat == P_S[id] - 1);
        if (primed) begin
            check(id, "in_ready", d_rdy, (in_slot && !rst_v[id]) ? (32'd1 << ch) : 32'd0);
            check(id, "slot_start", d_ss, 32'(ss));
            check(id, "frame_start", d_fs, 32'(fs));
            check(id, "slot_empty", d_se, 32'(exp_empty[id]));
            if (k == 3) begin
                check(id, "rst_out_data", d_od, 32'd0);
                check(id, "rst_out_ch", d_oc, 32'd0);
            end
        end
        xfer = in_slot && iv[id][ch] && !rst_v[id];
        if (xfer) sbq[id].push_back('{cyc + 1, idat[id][ch*8 +: 8], ch});
        if (rst_v[id]) begin
            running[id] = 1'b0; seen[id] = 1'b0; exp_empty[id] = 1'b0;
        end else if (running[id]) begin
            if (in_slot) seen[id] = (beat == 0 ? 1'b0 : seen[id]) | xfer;
            exp_empty[id] = last && !seen[id];
            if (last && !en_v[id]) running[id] = 1'b0;
            else n[id]++;
        end else begin
            exp_empty[id] = 1'b0;
            if (en_v[id]) begin
                running[id] = 1'b1;
                n[id] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (primed) begin
            for (int id = 0; id < 2; id++) begin
                logic [31:0] d_rdy, d_ss, d_fs, d_se, d_ov, d_od, d_oc;
                bit due_now;
                exp_t e;
                sample(id, d_rdy, d_ss, d_fs, d_se, d_ov, d_od, d_oc);
                due_now = (sbq[id].size() > 0) && (sbq[id][0].due <= cyc);
                check(id, "out_valid", d_ov, 32'(due_now));
                if (due_now) begin
                    e = sbq[id].pop_front();
                    if (d_ov === 32'd1) begin
                        check(id, "out_data", d_od, 32'(e.d));
                        check(id, "out_ch", d_oc, 32'(e.ch));
                    end
                end
            end
        end
    end

    initial begin
        cyc = 0; checks = 0; errors = 0; primed = 1'b0;
        for (int id = 0; id < 2; id++) begin
            rst_v[id] = 1'b1; en_v[id] = 1'b0; iv[id] = 4'h0; idat[id] = 32'h0;
            running[id] = 1'b0; n[id] = 0; seen[id] = 1'b0; exp_empty[id] = 1'b0;
        end
        for (int k = 0; k < 1300; k++) begin
            @(negedge clk);
            for (int id = 0; id < 2; id++) drive(id, k);
            #1;
            for (int id = 0; id < 2; id++) step(id, k);
            if (rst_v[0] && rst_v[1]) primed = 1'b1;
        end
        @(negedge clk);
        #2;
        for (int id = 0; id < 2; id++) check(id, "sb_drain", 32'(sbq[id].size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
